// File: rtl/wb_uart_rx.sv
// Wishbone-slave 8N1 UART receiver with 16x oversampling, programmable divisor,
// receive FIFO and level interrupt.
module wb_uart_rx #(
  parameter logic [15:0] DIV_RESET = 16'd0,
  parameter int          FIFO_AW   = 3
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_data_w,
  output logic [31:0] wb_data_r,
  input  logic        wb_we,
  input  logic [3:0]  wb_sel,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  output logic        wb_ack,
  input  logic        rx_i,
  output logic        irq
);

  // state   | meaning
  // S_IDLE  | waiting for a 1->0 edge seen on consecutive ticks
  // S_START | checking the start bit at mid-bit (8th tick)
  // S_DATA  | sampling 8 data bits, one every 16 ticks, LSB first
  // S_STOP  | checking the stop bit, pushing the byte or flagging frame_err
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam int               DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

  logic               ack_q, ack_d;
  logic [31:0]        data_r_q, data_r_d;
  logic               irq_q, irq_d;
  logic [15:0]        div_q, div_d;
  logic               rx_en_q, rx_en_d;
  logic               irq_en_q, irq_en_d;
  logic               ovr_q, ovr_d;
  logic               ferr_q, ferr_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic [15:0]        tcnt_q, tcnt_d;
  logic               sync1_q, sync2_q;
  logic               prev_q, prev_d;
  logic [1:0]         state_q, state_d;
  logic [3:0]         scnt_q, scnt_d;
  logic [2:0]         bidx_q, bidx_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         mem_q [DEPTH];

  logic        access, rd_acc, wr_acc, wr_status;
  logic [1:0]  adr;
  logic        not_empty, full, pop, push, push_ok, ovr_set, ferr_set, tick, rxs;
  logic [31:0] rdata;
  logic        unused;

  assign unused = ^{wb_sel, wb_adr[31:4], wb_adr[1:0], wb_data_w[31:16]};

  assign rxs       = sync2_q;
  assign adr       = wb_adr[3:2];
  assign access    = wb_cyc & wb_stb & ~ack_q;
  assign rd_acc    = access & ~wb_we;
  assign wr_acc    = access & wb_we;
  assign wr_status = wr_acc & (adr == 2'd1);
  assign not_empty = (cnt_q != '0);
  assign full      = (cnt_q == DEPTH_C);
  assign pop       = rd_acc & (adr == 2'd0) & not_empty;
  // A push into a full FIFO still lands if the same cycle pops.
  assign push_ok   = push & (~full | pop);
  assign ovr_set   = push & full & ~pop;
  assign tick      = rx_en_q & (tcnt_q == 16'd0);

  always_comb begin
    rdata = 32'd0;
    unique case (adr)
      2'd0: rdata = not_empty ? {24'd0, mem_q[rd_ptr_q]} : 32'd0;
      2'd1: rdata = {28'd0, ferr_q, ovr_q, full, not_empty};
      2'd2: rdata = {16'd0, div_q};
      2'd3: rdata = {30'd0, irq_en_q, rx_en_q};
      default: rdata = 32'd0;
    endcase
  end

  always_comb begin
    ack_d    = access;
    data_r_d = rd_acc ? rdata : 32'd0;
    div_d    = div_q;
    rx_en_d  = rx_en_q;
    irq_en_d = irq_en_q;
    if (wr_acc && adr == 2'd2) div_d = wb_data_w[15:0];
    if (wr_acc && adr == 2'd3) begin
      rx_en_d  = wb_data_w[0];
      irq_en_d = wb_data_w[1];
    end
    ovr_d  = (ovr_q & ~(wr_status & wb_data_w[2])) | ovr_set;
    ferr_d = (ferr_q & ~(wr_status & wb_data_w[3])) | ferr_set;
    irq_d  = irq_en_q & (not_empty | ovr_q | ferr_q);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + FIFO_AW'(push_ok);
    rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
    cnt_d    = cnt_q;
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Oversample timer: reloads with DIV on terminal count, giving a tick every DIV+1 clocks.
  always_comb begin
    if (!rx_en_q)             tcnt_d = 16'd0;
    else if (tcnt_q == 16'd0) tcnt_d = div_q;
    else                      tcnt_d = tcnt_q - 16'd1;
  end

  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    bidx_d   = bidx_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    prev_d   = tick ? rxs : prev_q;
    if (!rx_en_q) begin
      state_d = S_IDLE;
    end else if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rxs && prev_q) begin
            state_d = S_START;
            scnt_d  = 4'd0;
          end
        end
        S_START: begin
          if (scnt_q == 4'd7) begin
            scnt_d  = 4'd0;
            bidx_d  = 3'd0;
            state_d = rxs ? S_IDLE : S_DATA;
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
        S_DATA: begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            shift_d = {rxs, shift_q[7:1]};
            bidx_d  = bidx_q + 3'd1;
            if (bidx_q == 3'd7) state_d = S_STOP;
          end
        end
        S_STOP: begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            push     = rxs;
            ferr_set = ~rxs;
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      ack_q    <= 1'b0;
      data_r_q <= 32'd0;
      irq_q    <= 1'b0;
      div_q    <= DIV_RESET;
      rx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      tcnt_q   <= 16'd0;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      state_q  <= S_IDLE;
      scnt_q   <= 4'd0;
      bidx_q   <= 3'd0;
      shift_q  <= 8'd0;
    end else begin
      ack_q    <= ack_d;
      data_r_q <= data_r_d;
      irq_q    <= irq_d;
      div_q    <= div_d;
      rx_en_q  <= rx_en_d;
      irq_en_q <= irq_en_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      sync1_q  <= rx_i;
      sync2_q  <= sync1_q;
      prev_q   <= prev_d;
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      bidx_q   <= bidx_d;
      shift_q  <= shift_d;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  assign wb_ack    = ack_q;
  assign wb_data_r = data_r_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_wb_uart_rx.sv
// Bench for wb_uart_rx: register vector table plus serial frames checked against a byte scoreboard.
module tb_wb_uart_rx;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [31:0] wb_adr;
  logic [31:0] wb_data_w;
  logic [31:0] wb_data_r;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_ack;
  logic        rx_i;
  logic        irq;

  wb_uart_rx dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_adr(wb_adr), .wb_data_w(wb_data_w),
    .wb_data_r(wb_data_r), .wb_we(wb_we), .wb_sel(wb_sel), .wb_cyc(wb_cyc),
    .wb_stb(wb_stb), .wb_ack(wb_ack), .rx_i(rx_i), .irq(irq)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t       vt [18];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sbq [$];
  bit         ov_m = 0;
  bit         fe_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [3:0] a, input logic [31:0] wd,
                     output logic [31:0] rd);
    int n;
    rd = 32'd0;
    @(negedge wb_clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = {28'd0, a}; wb_data_w = wd;
    n = 0;
    do begin
      @(posedge wb_clk); #1; n++;
    end while (!wb_ack && n < 8);
    if (!wb_ack) begin
      n_vec++; n_err++;
      $display("FAIL ack_timeout: got no ack after %0d cycles, expected ack within 8", n);
    end else begin
      rd = wb_data_r;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(1'b1, a, d, dummy);
  endtask

  function automatic logic [31:0] exp_status();
    return {28'd0, fe_m, ov_m, sbq.size() == 8, sbq.size() != 0};
  endfunction

  task automatic check_status(input string name);
    logic [31:0] v;
    bus(1'b0, 4'h4, 32'd0, v);
    chk(name, v, exp_status());
  endtask

  task automatic read_rx(input string name);
    logic [31:0] v;
    logic [31:0] e;
    bus(1'b0, 4'h0, 32'd0, v);
    e = (sbq.size() != 0) ? {24'd0, sbq.pop_front()} : 32'd0;
    chk(name, v, e);
  endtask

  task automatic send_byte(input logic [7:0] b, input int bclks, input bit stop_ok);
    @(negedge wb_clk);
    rx_i = 1'b0;
    repeat (bclks) @(negedge wb_clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (bclks) @(negedge wb_clk);
    end
    rx_i = stop_ok;
    repeat (bclks) @(negedge wb_clk);
    rx_i = 1'b1;
    repeat (2 * bclks) @(negedge wb_clk);
    if (!stop_ok)            fe_m = 1'b1;
    else if (sbq.size() < 8) sbq.push_back(b);
    else                     ov_m = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    int acks;

    vt[0]  = '{1'b0, 4'h0, 32'h0,        32'h0};
    vt[1]  = '{1'b0, 4'h4, 32'h0,        32'h0};
    vt[2]  = '{1'b0, 4'h8, 32'h0,        32'h0};
    vt[3]  = '{1'b0, 4'hC, 32'h0,        32'h0};
    vt[4]  = '{1'b1, 4'h8, 32'h00001234, 32'h0};
    vt[5]  = '{1'b0, 4'h8, 32'h0,        32'h00001234};
    vt[6]  = '{1'b1, 4'h8, 32'hFFFFABCD, 32'h0};
    vt[7]  = '{1'b0, 4'h8, 32'h0,        32'h0000ABCD};
    vt[8]  = '{1'b1, 4'hC, 32'hFFFFFFFF, 32'h0};
    vt[9]  = '{1'b0, 4'hC, 32'h0,        32'h00000003};
    vt[10] = '{1'b1, 4'h0, 32'h000000FF, 32'h0};
    vt[11] = '{1'b0, 4'h0, 32'h0,        32'h0};
    vt[12] = '{1'b1, 4'hC, 32'h0,        32'h0};
    vt[13] = '{1'b0, 4'hC, 32'h0,        32'h0};
    vt[14] = '{1'b1, 4'h4, 32'h0000000C, 32'h0};
    vt[15] = '{1'b0, 4'h4, 32'h0,        32'h0};
    vt[16] = '{1'b1, 4'h8, 32'h0,        32'h0};
    vt[17] = '{1'b0, 4'h8, 32'h0,        32'h0};

    wb_rst = 1'b1; rx_i = 1'b1; wb_adr = 32'd0; wb_data_w = 32'd0;
    wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b0; wb_stb = 1'b0;
    repeat (3) @(negedge wb_clk);
    chk("rst_ack", {31'd0, wb_ack}, 32'd0);
    chk("rst_data_r", wb_data_r, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    wb_rst = 1'b0;
    repeat (2) @(negedge wb_clk);

    for (int i = 0; i < 18; i++) begin
      bus(vt[i].we, vt[i].adr, vt[i].wd, rd);
      if (!vt[i].we) chk($sformatf("vec%0d", i), rd, vt[i].exp);
    end

    // held request: ack, dead cycle, ack, dead cycle
    @(negedge wb_clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'hC;
    acks = 0;
    repeat (4) begin
      @(posedge wb_clk); #1;
      if (wb_ack) acks++;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    chk("b2b_acks", acks, 2);

    // single byte at DIV=0
    wr_reg(4'h8, 32'd0);
    wr_reg(4'hC, 32'h1);
    send_byte(8'hA5, 16, 1'b1);
    check_status("a5_status");
    chk("a5_status_const", exp_status(), 32'h1);
    read_rx("a5_data");
    check_status("a5_status_after");

    // DIV=3, two bytes in order
    wr_reg(4'h8, 32'd3);
    send_byte(8'h3C, 64, 1'b1);
    send_byte(8'hC3, 64, 1'b1);
    read_rx("div3_first");
    read_rx("div3_second");

    // overrun: nine bytes into an eight-deep FIFO
    wr_reg(4'h8, 32'd0);
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 16, 1'b1);
    check_status("ovr_status_full");
    for (int i = 0; i < 8; i++) read_rx($sformatf("ovr_read%0d", i));
    check_status("ovr_status_drained");
    wr_reg(4'h4, 32'h4);
    ov_m = 1'b0;
    check_status("ovr_cleared");

    // frame error and interrupt
    send_byte(8'h55, 16, 1'b0);
    check_status("ferr_status");
    wr_reg(4'hC, 32'h3);
    repeat (2) @(posedge wb_clk); #1;
    chk("ferr_irq_set", {31'd0, irq}, 32'd1);
    wr_reg(4'h4, 32'h8);
    fe_m = 1'b0;
    repeat (2) @(posedge wb_clk); #1;
    chk("ferr_irq_clr", {31'd0, irq}, 32'd0);
    check_status("ferr_cleared");

    // short low glitch must be rejected
    wr_reg(4'hC, 32'h1);
    @(negedge wb_clk);
    rx_i = 1'b0;
    repeat (4) @(negedge wb_clk);
    rx_i = 1'b1;
    repeat (64) @(negedge wb_clk);
    check_status("glitch_status");

    // reset mid-frame
    wr_reg(4'hC, 32'h3);
    send_byte(8'h11, 16, 1'b1);
    repeat (2) @(posedge wb_clk); #1;
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    wr_reg(4'h8, 32'h7);
    wr_reg(4'h8, 32'h0);
    @(negedge wb_clk);
    rx_i = 1'b0;
    repeat (16) @(negedge wb_clk);
    for (int i = 0; i < 4; i++) begin
      rx_i = i[0] ? 1'b1 : 1'b0;
      repeat (16) @(negedge wb_clk);
    end
    rx_i = 1'b1;
    repeat (8) @(negedge wb_clk);
    wb_rst = 1'b1;
    #1;
    chk("midrst_ack", {31'd0, wb_ack}, 32'd0);
    chk("midrst_data_r", wb_data_r, 32'd0);
    chk("midrst_irq", {31'd0, irq}, 32'd0);
    sbq.delete();
    fe_m = 1'b0; ov_m = 1'b0;
    rx_i = 1'b1;
    repeat (3) @(negedge wb_clk);
    wb_rst = 1'b0;
    repeat (40) @(negedge wb_clk);
    bus(1'b0, 4'h8, 32'd0, rd);
    chk("postrst_div", rd, 32'd0);
    bus(1'b0, 4'hC, 32'd0, rd);
    chk("postrst_ctrl", rd, 32'd0);
    check_status("postrst_status");
    wr_reg(4'hC, 32'h1);
    send_byte(8'h5A, 16, 1'b1);
    read_rx("postrst_5a");
    check_status("postrst_final_status");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_uart_rx.md
Name: wb_uart_rx

Overview:
- Wishbone-slave UART receiver: 8N1, 16x oversampling, programmable baud divisor, FIFO of received bytes, level interrupt.
- Sits on the SoC Wishbone interconnect beside the existing transmit-side UART as a data-bus responder.
- Its irq output feeds the core's external or timer interrupt input.
- Gives the SoC a real serial input path in place of the tied-off receive pad.

Parameters:
DIV_RESET, 16'd0, reset value of the DIV register.
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW (default 8 entries of 8 bits).

Ports:
wb_clk  input  1  system clock, all logic on rising edge
wb_rst  input  1  asynchronous, active-high reset
wb_adr  input  32  byte address; only [3:2] decoded
wb_data_w  input  32  write data
wb_data_r  output  32  read data, valid while wb_ack=1
wb_we  input  1  write enable
wb_sel  input  4  byte selects, ignored (full-word access only)
wb_cyc  input  1  bus cycle
wb_stb  input  1  strobe
wb_ack  output  1  single-cycle acknowledge
rx_i  input  1  asynchronous serial input, idle high
irq  output  1  registered level interrupt

Behaviour:
- Reset values: wb_ack=0, wb_data_r=0, irq=0, DIV=DIV_RESET, CTRL=0, FIFO empty, sticky flags 0, FSM=IDLE, both synchronizer flops=1.
- Register map (word offsets):
  - 0x0 RXDATA: read returns {24'd0, head byte} and pops; read when empty returns 0, no state change; write ignored.
  - 0x4 STATUS: bit0 not_empty, bit1 full, bit2 overrun (sticky), bit3 frame_err (sticky); write 1 clears bit2/bit3.
  - 0x8 DIV: [15:0] R/W, upper bits read 0.
  - 0xC CTRL: bit0 rx_en, bit1 irq_en, R/W.
- Bus handshake:
  - wb_ack rises one cycle after wb_cyc&wb_stb sampled high with wb_ack=0; high for exactly one cycle.
  - The cycle after wb_ack is never acked, so back-to-back requests take 2 cycles each.
  - Register write and FIFO pop take effect on the wb_ack cycle edge; read data is registered with wb_ack.
- Oversample tick:
  - 16-bit counter pulses one cycle every DIV+1 clocks while rx_en=1; held at 0 when rx_en=0.
  - Bit period = 16*(DIV+1) clocks.
- rx_i passes a 2-flop synchronizer; the FSM uses the synced value rxs.
- FSM (ticks counted by a 4-bit sample counter):
  - IDLE: a tick with rxs=0 and previous-tick rxs=1 -> START, counter=0.
  - START: at the 8th tick (mid-bit), rxs=0 -> DATA, counter=0, bit index=0; rxs=1 -> IDLE (glitch rejected).
  - DATA: every 16th tick, sample rxs into shift register LSB first; after bit 7 -> STOP.
  - STOP: at the 16th tick, rxs=1 -> push byte, IDLE. rxs=0 -> set frame_err, discard byte, IDLE; a new start then requires a seen 1->0 edge.
- FIFO:
  - Push when full: byte dropped, overrun=1, contents unchanged.
  - Simultaneous push and pop: both occur, count unchanged; same when full, with no overrun.
  - Pointers wrap modulo depth.
- rx_en cleared mid-frame: FSM -> IDLE next cycle, partial byte lost; FIFO and flags kept.
- irq: registered each cycle to irq_en & (not_empty | overrun | frame_err).
- wb_rst asserted at any time, including mid-frame or mid-bus-cycle: immediately forces all reset values.

Test Plan:
- DIV=0, CTRL=0x1, send 0xA5 at 16 clk/bit -> STATUS=0x1, RXDATA read=0x000000A5, then STATUS=0x0.
- DIV=3, send 0x3C then 0xC3 at 64 clk/bit -> reads return 0x3C then 0xC3, in order.
- DIV=0, send 9 bytes 0x01..0x09 without reading -> STATUS=0x7; eight reads return 0x01..0x08; STATUS=0x4; write 0x4 to STATUS -> 0x0.
- Frame with stop bit 0 -> FIFO empty, STATUS=0x8; with CTRL=0x3 irq=1; write 0x8 to STATUS -> irq=0 two cycles later.
- 4-clock low glitch on rx_i with DIV=0 -> no push, STATUS stays 0x0.
- wb_rst during DATA bit 4 -> all outputs 0, DIV=DIV_RESET; next full frame 0x5A is received correctly after CTRL is rewritten.
